// File: rtl/vproc_queue_arbiter.sv
// vproc_queue_arbiter: round-robin arbiter feeding one shared FIFO, with per-source in-flight credit caps.
// Optional VPROC_QUEUE_ARBITER_BYPASS_EN: a grant into an empty queue goes straight to a ready consumer.
module vproc_queue_arbiter #(
  parameter int REQ_CNT   = 4,
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int MAX_OUTST = 4,
  localparam int SW = $clog2(REQ_CNT),
  localparam int CW = $clog2(MAX_OUTST + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                             clk_i,
  input  logic                             async_rst_ni,
  input  logic                             sync_rst_ni,
  input  logic [REQ_CNT-1:0]               req_valid_i,
  input  logic [REQ_CNT-1:0][WIDTH-1:0]    req_data_i,
  output logic [REQ_CNT-1:0]               req_ready_o,
  input  logic                             deq_ready_i,
  output logic                             deq_valid_o,
  output logic [WIDTH-1:0]                 deq_data_o,
  output logic [SW-1:0]                    deq_src_o,
  input  logic                             done_valid_i,
  input  logic [SW-1:0]                    done_src_i,
  output logic [REQ_CNT-1:0][CW-1:0]       outst_o
);
  logic [WIDTH-1:0]   r_data [DEPTH];
  logic [SW-1:0]      r_src  [DEPTH];
  logic [AW-1:0]      r_rd, r_wr;
  logic [AW:0]        r_occ;
  logic [SW-1:0]      r_prio;
  logic [CW-1:0]      r_cnt [REQ_CNT];
  logic [REQ_CNT-1:0] w_elig, w_inc, w_dec;
  logic [SW-1:0]      w_gnt;
  logic               w_hs, w_full, w_byp, w_wr, w_deq;

  assign w_full = r_occ == (AW+1)'(DEPTH);

  for (genvar i = 0; i < REQ_CNT; i++) begin : g_src
    assign w_elig[i]      = req_valid_i[i] & (r_cnt[i] < CW'(MAX_OUTST));
    assign w_inc[i]       = w_hs & (w_gnt == SW'(i));
    // a retire against an empty credit count (e.g. after reset) is dropped
    assign w_dec[i]       = done_valid_i & (done_src_i == SW'(i)) & (r_cnt[i] != '0);
    assign req_ready_o[i] = w_inc[i];
    assign outst_o[i]     = r_cnt[i];
  end

  always_comb begin
    w_hs  = 1'b0;
    w_gnt = '0;
    for (int k = 0; k < REQ_CNT; k++)
      if (!w_hs && !w_full && w_elig[(int'(r_prio) + k) % REQ_CNT]) begin
        w_hs  = 1'b1;
        w_gnt = SW'((int'(r_prio) + k) % REQ_CNT);
      end
  end

`ifdef VPROC_QUEUE_ARBITER_BYPASS_EN
  assign w_byp = w_hs & deq_ready_i & (r_occ == '0);
`else
  assign w_byp = 1'b0;
`endif

  assign w_wr        = w_hs & ~w_byp;
  assign w_deq       = (r_occ != '0) & deq_ready_i;
  assign deq_valid_o = (r_occ != '0) | w_byp;
  assign deq_data_o  = w_byp ? req_data_i[w_gnt] : r_data[r_rd];
  assign deq_src_o   = w_byp ? w_gnt : r_src[r_rd];

  always_ff @(posedge clk_i) begin
    if (w_wr) begin
      r_data[r_wr] <= req_data_i[w_gnt];
      r_src[r_wr]  <= w_gnt;
    end
  end

  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni || !sync_rst_ni) begin
      r_rd   <= '0;
      r_wr   <= '0;
      r_occ  <= '0;
      r_prio <= '0;
      for (int i = 0; i < REQ_CNT; i++) r_cnt[i] <= '0;
    end else begin
      if (w_wr) r_wr <= r_wr + AW'(1);
      if (w_deq) r_rd <= r_rd + AW'(1);
      r_occ <= r_occ + (AW+1)'(w_wr) - (AW+1)'(w_deq);
      if (w_hs) r_prio <= (w_gnt == SW'(REQ_CNT - 1)) ? '0 : w_gnt + SW'(1);
      for (int i = 0; i < REQ_CNT; i++) r_cnt[i] <= r_cnt[i] + CW'(w_inc[i]) - CW'(w_dec[i]);
    end
  end
endmodule

// File: tb/tb_vproc_queue_arbiter.sv
// tb_vproc_queue_arbiter: directed stimulus with a queue-based reference model checked every cycle.
module tb_vproc_queue_arbiter;
  localparam int N = 4, W = 8, D = 8, M = 3;
  logic clk = 1'b0, async_rst_ni = 1'b0, sync_rst_ni = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0][W-1:0] req_data = '0;
  logic [N-1:0] req_ready;
  logic deq_ready = 1'b0, deq_valid;
  logic [W-1:0] deq_data;
  logic [1:0] deq_src;
  logic done_valid = 1'b0;
  logic [1:0] done_src = '0;
  logic [N-1:0][1:0] outst;
  int total = 0, bad = 0;
  logic [W-1:0] q_data[$];
  int q_src[$];
  int m_cnt[N];
  int m_prio;
  int last;

  vproc_queue_arbiter #(.REQ_CNT(N), .WIDTH(W), .DEPTH(D), .MAX_OUTST(M)) dut (
    .clk_i(clk), .async_rst_ni(async_rst_ni), .sync_rst_ni(sync_rst_ni),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_ready_o(req_ready),
    .deq_ready_i(deq_ready), .deq_valid_o(deq_valid), .deq_data_o(deq_data), .deq_src_o(deq_src),
    .done_valid_i(done_valid), .done_src_i(done_src), .outst_o(outst)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic clear_model();
    q_data.delete();
    q_src.delete();
    for (int s = 0; s < N; s++) m_cnt[s] = 0;
    m_prio = 0;
  endtask

  // Reference: grant = first eligible source at or after prio; FIFO of {src,data}; credits as plain ints.
  always @(negedge clk) begin
    int g;
    logic [N-1:0] er;
    bit byp, ev;
    logic [W-1:0] ed;
    int es;
    if (!async_rst_ni) clear_model();
    g = -1;
    if (q_data.size() < D)
      for (int k = 0; k < N; k++)
        if (g < 0 && req_valid[(m_prio + k) % N] && m_cnt[(m_prio + k) % N] < M) g = (m_prio + k) % N;
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    byp = 0;
`ifdef VPROC_QUEUE_ARBITER_BYPASS_EN
    byp = g >= 0 && q_data.size() == 0 && deq_ready;
`endif
    ev = q_data.size() > 0 || byp;
    check("req_ready", req_ready, er);
    check("deq_valid", deq_valid, ev);
    if (ev) begin
      ed = byp ? req_data[g] : q_data[0];
      es = byp ? g : q_src[0];
      check("deq_data", deq_data, ed);
      check("deq_src", deq_src, es);
    end
    for (int s = 0; s < N; s++) check("outst", outst[s], m_cnt[s]);
    if (!async_rst_ni || !sync_rst_ni) clear_model();
    else begin
      if (done_valid && m_cnt[done_src] > 0) m_cnt[done_src]--;
      if (ev && deq_ready && !byp) begin
        void'(q_data.pop_front());
        void'(q_src.pop_front());
      end
      if (g >= 0) begin
        if (!byp) begin
          q_data.push_back(req_data[g]);
          q_src.push_back(g);
        end
        m_cnt[g]++;
        m_prio = (g + 1) % N;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sreset();
    req_valid = '0;
    done_valid = 1'b0;
    sync_rst_ni = 1'b0;
    cyc();
    sync_rst_ni = 1'b1;
  endtask

  task automatic drain();
    req_valid = '0;
    deq_ready = 1'b1;
    for (int s = 0; s < N; s++)
      for (int r = 0; r < M; r++) begin
        done_valid = 1'b1;
        done_src = 2'(s);
        cyc();
      end
    done_valid = 1'b0;
  endtask

  initial begin
    cyc();
    cyc();
    check("rst_deq_valid", deq_valid, 0);
    check("rst_outst", outst, 0);
    check("rst_ready", req_ready, 0);
    async_rst_ni = 1'b1;
    // single requester
    deq_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      req_valid = 4'b0001;
      req_data[0] = 8'(k * 8'h11);
      #1 check("single_ready", req_ready, 4'b0001);
      cyc();
      req_valid = '0;
      #1;
      check("single_valid", deq_valid, 1);
      check("single_data", deq_data, k * 8'h11);
      check("single_src", deq_src, 0);
    end
    drain();
    // round-robin with immediate retires
    sreset();
    deq_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      req_valid = 4'hf;
      for (int s = 0; s < N; s++) req_data[s] = 8'(s * 16 + k);
      done_valid = k > 0;
      done_src = 2'(last);
      #1 check("rr_grant", req_ready, 1 << (k % 4));
      last = k % 4;
      cyc();
    end
    drain();
    // credit cap
    sreset();
    deq_ready = 1'b1;
    req_valid = 4'b0010;
    req_data[1] = 8'ha0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("cap_cnt", outst[1], k + 1);
    end
    check("cap_blocked", req_ready[1], 0);
    done_valid = 1'b1;
    done_src = 2'd1;
    cyc();
    done_valid = 1'b0;
    check("cap_retired", outst[1], 2);
    check("cap_regrant", req_ready[1], 1);
    cyc();
    check("cap_refill", outst[1], 3);
    drain();
    // full queue
    sreset();
    deq_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      req_valid = 4'b0111;
      for (int s = 0; s < N; s++) req_data[s] = 8'(8'h80 + s * 16 + k);
      cyc();
    end
    check("full_ready", req_ready, 0);
    check("full_head", deq_data, 8'h80);
    cyc();
    deq_ready = 1'b1;
    #1 check("full_deq_ready", req_ready, 0);
    cyc();
    deq_ready = 1'b0;
    #1 check("full_regrant", req_ready, 4'b0100);
    check("full_next_head", deq_data, 8'h91);
    cyc();
    drain();
    // simultaneous accept and retire
    sreset();
    deq_ready = 1'b1;
    req_valid = 4'b0100;
    cyc();
    cyc();
    check("sim_cnt", outst[2], 2);
    done_valid = 1'b1;
    done_src = 2'd2;
    cyc();
    check("sim_same", outst[2], 2);
    req_valid = '0;
    done_src = 2'd3;
    cyc();
    check("sim_zero", outst[3], 0);
    check("sim_other", outst[2], 2);
    done_valid = 1'b0;
    drain();
    // mid-operation resets
    sreset();
    deq_ready = 1'b0;
    req_valid = 4'hf;
    repeat (5) cyc();
    req_valid = '0;
    check("mid_queued", deq_valid, 1);
    sync_rst_ni = 1'b0;
    cyc();
    sync_rst_ni = 1'b1;
    check("srst_valid", deq_valid, 0);
    check("srst_outst", outst, 0);
    req_valid = 4'hf;
    #1 check("srst_first", req_ready, 4'b0001);
    repeat (5) cyc();
    req_valid = '0;
    @(posedge clk);
    #3 async_rst_ni = 1'b0;
    #1;
    check("arst_valid", deq_valid, 0);
    check("arst_outst", outst, 0);
    cyc();
    async_rst_ni = 1'b1;
    done_valid = 1'b1;
    done_src = 2'd0;
    cyc();
    done_valid = 1'b0;
    check("arst_retire", outst[0], 0);
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
